// File: rtl/sub_pkg.sv
// Shared definitions for the sequential 32-bit subtractor: FSM encoding and default geometry.
package sub_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int SLICE_DEF = 4;
  localparam int NSLICE    = WIDTH_DEF / SLICE_DEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sub4b.sv
// Combinational 4-bit ripple-borrow subtractor built from four full-subtractor cells.
module sub4b
  import sub_pkg::*;
(
  output logic [3:0] diff,
  output logic       bout,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin
);

  logic [4:0] chain;

  assign chain[0] = bin;

  // A cell borrows when a < b, or when a == b and a borrow arrives from below.
  for (genvar i = 0; i < 4; i++) begin : g_cell
    assign diff[i]      = a[i] ^ b[i] ^ chain[i];
    assign chain[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & chain[i]);
  end

  assign bout = chain[4];

endmodule

// File: rtl/sub32b_seq.sv
// Multi-cycle subtractor resolving one 4-bit slice per clock with a registered borrow.
// Optional signed-overflow output is enabled by defining SUB_OVF_EN.
module sub32b_seq
  import sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] minuend,
  input  logic [WIDTH-1:0] subtrahend,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NS = WIDTH / SLICE;
  localparam int KW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NS - 1);

  state_t           state;
  state_t           state_nxt;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic             bin_q;
  logic             borrow_q;
  logic             ready_q;
  logic             accept;
  logic [SLICE-1:0] a_sl;
  logic [SLICE-1:0] b_sl;
  logic [SLICE-1:0] d_sl;
  logic             bout_sl;
`ifdef SUB_OVF_EN
  logic             ovf_q;
`endif

  assign a_sl = a_q[k*SLICE +: SLICE];
  assign b_sl = b_q[k*SLICE +: SLICE];

  sub4b u_slice (
    .diff (d_sl),
    .bout (bout_sl),
    .a    (a_sl),
    .b    (b_sl),
    .bin  (bin_q)
  );

  // ready_q keeps in_ready low while reset is held, without a combinational path from reset.
  assign in_ready  = (state == ST_IDLE) && ready_q;
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign diff      = diff_q;
  assign borrow    = borrow_q;
`ifdef SUB_OVF_EN
  assign ovf       = ovf_q;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_RUN;
      ST_RUN:  if (k == K_LAST) state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      ready_q  <= 1'b0;
      k        <= '0;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      bin_q    <= 1'b0;
      borrow_q <= 1'b0;
`ifdef SUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      ready_q <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            a_q      <= minuend;
            b_q      <= subtrahend;
            k        <= '0;
            bin_q    <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
`ifdef SUB_OVF_EN
            ovf_q    <= 1'b0;
`endif
          end
        end
        ST_RUN: begin
          diff_q[k*SLICE +: SLICE] <= d_sl;
          bin_q                    <= bout_sl;
          k                        <= k + 1'b1;
          // The top slice's MSB is the sign of the full difference.
          if (k == K_LAST) begin
            borrow_q <= bout_sl;
`ifdef SUB_OVF_EN
            ovf_q    <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d_sl[SLICE-1] != a_q[WIDTH-1]);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sub32b_seq.sv
// Scoreboard bench for sub32b_seq: expectations queued at accept, compared when results are consumed.
module tb_sub32b_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] minuend;
  logic [31:0] subtrahend;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] diff;
  logic        borrow;
`ifdef SUB_OVF_EN
  logic        ovf;
`endif

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic        br;
    logic        ov;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   errs = 0;
  int   cyc = 0;
  int   last_acc = 0;
  bit   have_last = 0;
  bit   chk_int = 0;
  bit   ov_seen = 0;

  sub32b_seq dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .minuend    (minuend),
    .subtrahend (subtrahend),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow     (borrow)
`ifdef SUB_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      errs++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.a   = a;
    e.b   = b;
    e.d   = a - b;
    e.br  = (a < b);
    e.ov  = (a[31] != b[31]) && (e.d[31] != a[31]);
    e.acc = 0;
    return e;
  endfunction

  // Monitor: queue expectations on accept, check latency on first out_valid, compare on handshake.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (in_valid && in_ready) begin
        e     = model(minuend, subtrahend);
        e.acc = cyc + 1;
        sb.push_back(e);
        if (chk_int && have_last) checkOutput("issue_interval", cyc - last_acc, 10);
        last_acc  = cyc;
        have_last = 1;
      end
      if (out_valid && !ov_seen) begin
        ov_seen = 1;
        checkOutput("result_pending", sb.size() > 0, 1);
        if (sb.size() > 0) checkOutput("latency", cyc - sb[0].acc, 8);
      end
      if (out_valid && out_ready && sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("diff", diff, e.d);
        checkOutput("borrow", borrow, e.br);
`ifdef SUB_OVF_EN
        checkOutput("ovf", ovf, e.ov);
`endif
        ov_seen = 0;
      end
    end else begin
      ov_seen = 0;
    end
  end

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    int n;
    minuend    = a;
    subtrahend = b;
    in_valid   = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) checkOutput("accept_timeout", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("drain", sb.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t h;
    int   n;
    reset      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    minuend    = '0;
    subtrahend = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_diff", diff, 0);
    checkOutput("rst_borrow", borrow, 0);
`ifdef SUB_OVF_EN
    checkOutput("rst_ovf", ovf, 0);
`endif
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("ready_after_rst", in_ready, 1);

    applyStimulus(32'h0000_0005, 32'h0000_0003); waitDrain();
    applyStimulus(32'h0000_0000, 32'h0000_0001); waitDrain();
    applyStimulus(32'h8000_0000, 32'h0000_0001); waitDrain();
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF); waitDrain();
    applyStimulus(32'h7FFF_FFFF, 32'hFFFF_FFFF); waitDrain();

    // Consumer stalls in DONE; result must hold and new operands must be refused.
    out_ready = 1'b0;
    h = model(32'h1234_5678, 32'h9ABC_DEF0);
    applyStimulus(32'h1234_5678, 32'h9ABC_DEF0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("hold_reach_done", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      in_valid   = (i % 2 == 0);
      minuend    = $urandom();
      subtrahend = $urandom();
      @(posedge clk); #1;
      checkOutput("hold_out_valid", out_valid, 1);
      checkOutput("hold_in_ready", in_ready, 0);
      checkOutput("hold_diff", diff, h.d);
      checkOutput("hold_borrow", borrow, h.br);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    checkOutput("hold_released", out_valid, 0);
    checkOutput("hold_no_accept", sb.size(), 0);

    // Reset during the fourth RUN cycle abandons the operation.
    applyStimulus(32'hFFFF_0000, 32'h0000_0001);
    repeat (3) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_diff", diff, 0);
    checkOutput("midrst_borrow", borrow, 0);
    checkOutput("midrst_in_ready", in_ready, 0);
    sb.delete();
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("midrst_ready_after", in_ready, 1);
    applyStimulus(32'h0000_0010, 32'h0000_0001); waitDrain();

    // Back-to-back random traffic with both handshakes held high.
    chk_int    = 1;
    have_last  = 0;
    out_ready  = 1'b1;
    minuend    = $urandom();
    subtrahend = $urandom();
    in_valid   = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      n = 0;
      while (!in_ready && n < 30) begin
        @(posedge clk); #1;
        n++;
      end
      if (!in_ready) begin
        checkOutput("b2b_ready", in_ready, 1);
        break;
      end
      @(posedge clk); #1;
      minuend    = $urandom();
      subtrahend = $urandom();
    end
    in_valid = 1'b0;
    chk_int  = 0;
    waitDrain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/sub32b_seq.md
# sub32b_seq

Multi-cycle 32-bit subtractor computing minuend − subtrahend one 4-bit slice per clock through a ripple-borrow chain, with a registered borrow carried between slices. It is the arithmetic counterpart of the ripple-carry adder path in the accumulator datapath, used for difference and compare operations without a 32-bit combinational borrow chain. Operands enter and results leave through valid/ready handshakes.

## Interface
- WIDTH, 32, operand width; must be a multiple of SLICE
- SLICE, 4, bits resolved per cycle
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous reset, active-low: state clears on a rising clk edge while reset = 0
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands
- minuend  input  WIDTH  operand a
- subtrahend  input  WIDTH  operand b
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  a − b, modulo 2^WIDTH
- borrow  output  1  1 when a < b unsigned
- ovf  output  1  signed overflow; present only with SUB_OVF_EN

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: latch both operands, set slice counter k = 0, clear internal borrow, go to RUN.
- RUN:
  - in_ready = 0; in_valid is ignored.
  - Each cycle, slice k computes diff[k*SLICE +: SLICE] = a_slice − b_slice − bin. bin is the borrow registered from slice k−1, or 0 for k = 0.
  - The slice difference and its borrow-out are registered, then k increments.
  - After slice WIDTH/SLICE − 1, go to DONE. borrow takes the final borrow-out.
- DONE:
  - out_valid = 1; diff, borrow and ovf are held stable.
  - On out_ready: go to IDLE.
  - in_ready stays 0 in DONE, even in the cycle the result is accepted.
- Arithmetic is unsigned two's-complement wrap. borrow = 1 exactly when minuend < subtrahend unsigned.
- Reset values:
  - Asserting reset in any state, including mid-RUN or in DONE, abandons the operation and returns to IDLE.
  - While reset = 0: in_ready = 0, out_valid = 0, diff = 0, borrow = 0, ovf = 0.
  - In the first cycle after reset deasserts, in_ready = 1.

## Timing
- The accept edge is E0. Slices are resolved on edges E1..E8 (WIDTH/SLICE = 8).
- out_valid is high in the cycle after E8: latency is 8 cycles from accept to result visible.
- Minimum issue interval is 10 cycles: accept cycle, 8 RUN cycles, and at least one DONE cycle, with the next accept in IDLE.
- diff bits already resolved are visible during RUN but are not valid until out_valid.
- All outputs are driven from registers or decoded from the state register. There is no combinational path from in_valid or out_ready to any output.

## Configuration
- SUB_OVF_EN defined:
  - Port ovf exists.
  - At DONE, ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]), using the latched operands.
  - ovf is held with diff and cleared by reset.
- SUB_OVF_EN undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package/header sub_pkg holds:
  - state encoding constants ST_IDLE, ST_RUN, ST_DONE
  - default WIDTH and SLICE
  - NSLICE = WIDTH/SLICE
- One sub-module, sub4b: a combinational 4-bit ripple-borrow subtractor with ports (diff[3:0], bout, a[3:0], b[3:0], bin).
  - Built from four full-subtractor cells, mirroring the adder's full-adder cells.
  - sub32b_seq instantiates one sub4b and muxes operand slices by k.

## Test plan
- 0x00000005 − 0x00000003 → diff 0x00000002, borrow 0, out_valid exactly 8 cycles after accept.
- 0x00000000 − 0x00000001 → diff 0xFFFFFFFF, borrow 1; with SUB_OVF_EN, ovf 0.
- 0x80000000 − 0x00000001 → diff 0x7FFFFFFF, borrow 0; with SUB_OVF_EN, ovf 1.
- Hold out_ready = 0 for 5 cycles in DONE → diff and borrow stable and out_valid held; in_valid pulses during that time are not accepted.
- Assert reset in the 4th RUN cycle → next cycle: out_valid 0, diff 0, borrow 0; in_ready 1 after deassert. A new operation 0x10 − 0x01 yields 0x0F.
- Back-to-back operations with in_valid and out_ready held high → accepts spaced exactly 10 cycles apart, and every result matches the reference model a − b mod 2^32 over 1000 random pairs.
